playfield_renderer: RTL and testbench

Downstream consumer of the block memory that holds the playfield. It generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and maps each visible pixel onto a playfield cell. It drives the cell address into the block memory, converts the returned 3-bit colour code to 12-bit RGB through a fixed palette, and emits sync signals aligned with that RGB. It also raises a once-per-frame tick so game logic can update memory during vertical blanking.

---
 rtl/playfield_renderer_pkg.sv | 49 ++++
 rtl/playfield_renderer_if.sv | 15 +
 rtl/playfield_renderer_vga_timing.sv | 30 +++
 rtl/playfield_renderer.sv | 109 ++++++++++
 tb/tb_playfield_renderer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/playfield_renderer_pkg.sv
// rtl/playfield_renderer_pkg.sv - VGA 640x480 timing constants, colour types and palette
package playfield_renderer_pkg;

  typedef logic [2:0]  color_code_t;
  typedef logic [11:0] rgb_t;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam rgb_t RGB_BLANK      = 12'h000;
  localparam rgb_t RGB_BACKGROUND = 12'h333;
  localparam rgb_t RGB_GRID       = 12'h111;

  localparam rgb_t PAL_BLACK   = 12'h000;
  localparam rgb_t PAL_RED     = 12'hF00;
  localparam rgb_t PAL_GREEN   = 12'h0F0;
  localparam rgb_t PAL_BLUE    = 12'h00F;
  localparam rgb_t PAL_YELLOW  = 12'hFF0;
  localparam rgb_t PAL_MAGENTA = 12'hF0F;
  localparam rgb_t PAL_CYAN    = 12'h0FF;
  localparam rgb_t PAL_ORANGE  = 12'hF80;

  function automatic rgb_t palette(color_code_t code);
    case (code)
      3'd0:    return PAL_BLACK;
      3'd1:    return PAL_RED;
      3'd2:    return PAL_GREEN;
      3'd3:    return PAL_BLUE;
      3'd4:    return PAL_YELLOW;
      3'd5:    return PAL_MAGENTA;
      3'd6:    return PAL_CYAN;
      default: return PAL_ORANGE;
    endcase
  endfunction

endpackage

// File: rtl/playfield_renderer_if.sv
// rtl/playfield_renderer_if.sv - playfield memory read port and video outputs
interface playfield_renderer_if;
  import playfield_renderer_pkg::*;

  logic [4:0]  vaddr;
  logic [4:0]  haddr;
  color_code_t memval;
  logic        hsync;
  logic        vsync;
  rgb_t        rgb;
  logic        frame_tick;

  modport master (output vaddr, haddr, hsync, vsync, rgb, frame_tick, input memval);
  modport slave  (input vaddr, haddr, hsync, vsync, rgb, frame_tick, output memval);
endinterface

// File: rtl/playfield_renderer_vga_timing.sv
// rtl/playfield_renderer_vga_timing.sv - 800x525 pixel/line counters with raw sync and visible decode
module vga_timing
  import playfield_renderer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_TOTAL - 10'd1) begin
      hcount <= '0;
      vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  assign visible   = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
  assign hsync_raw = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vsync_raw = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));

endmodule

// File: rtl/playfield_renderer.sv
// rtl/playfield_renderer.sv - maps VGA pixels onto playfield cells and colours them, 2-stage pipeline
// Optional GRID_LINES_EN draws cell-local row/column 0 in the grid colour.
module playfield_renderer
  import playfield_renderer_pkg::*;
#(
  parameter int BLOCKS_VERTICAL   = 20,
  parameter int BLOCKS_HORIZONTAL = 10,
  parameter int CELL_SIZE         = 16,
  parameter int ORIGIN_X          = 240,
  parameter int ORIGIN_Y          = 80
) (
  input logic                  clk,
  input logic                  reset,
  playfield_renderer_if.master bus
);

  localparam int          CELL_SHIFT = $clog2(CELL_SIZE);
  localparam logic [10:0] ORG_X      = 11'(ORIGIN_X);
  localparam logic [10:0] ORG_Y      = 11'(ORIGIN_Y);
  localparam logic [10:0] FIELD_W    = 11'(BLOCKS_HORIZONTAL * CELL_SIZE);
  localparam logic [10:0] FIELD_H    = 11'(BLOCKS_VERTICAL * CELL_SIZE);

  logic [9:0]  hcount, vcount;
  logic        visible, hsync_raw, vsync_raw;
  logic [10:0] x, y;
  logic        in_field;

  vga_timing u_timing (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  // Unsigned 11-bit offsets: left/above the origin wraps to a large value and fails the bound check.
  assign x        = {1'b0, hcount} - ORG_X;
  assign y        = {1'b0, vcount} - ORG_Y;
  assign in_field = visible && (x < FIELD_W) && (y < FIELD_H);

  logic [4:0] vaddr_q, haddr_q;
  logic       visible_q, in_field_q, hsync_q, vsync_q, tick_q;
`ifdef GRID_LINES_EN
  logic       edge_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vaddr_q    <= '0;
      haddr_q    <= '0;
      visible_q  <= 1'b0;
      in_field_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      tick_q     <= 1'b0;
`ifdef GRID_LINES_EN
      edge_q     <= 1'b0;
`endif
    end else begin
      vaddr_q    <= in_field ? 5'(y >> CELL_SHIFT) : '0;
      haddr_q    <= in_field ? 5'(x >> CELL_SHIFT) : '0;
      visible_q  <= visible;
      in_field_q <= in_field;
      hsync_q    <= hsync_raw;
      vsync_q    <= vsync_raw;
      tick_q     <= (hcount == 10'd0) && (vcount == V_VISIBLE);
`ifdef GRID_LINES_EN
      edge_q     <= (x[CELL_SHIFT-1:0] == '0) || (y[CELL_SHIFT-1:0] == '0);
`endif
    end
  end

  rgb_t rgb_q;
  logic hsync_o, vsync_o, tick_o;

  // memval answers the address registered above, so colour lands in the same stage as the syncs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q   <= RGB_BLANK;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      tick_o  <= 1'b0;
    end else begin
      hsync_o <= hsync_q;
      vsync_o <= vsync_q;
      tick_o  <= tick_q;
      if (!visible_q)
        rgb_q <= RGB_BLANK;
      else if (!in_field_q)
        rgb_q <= RGB_BACKGROUND;
`ifdef GRID_LINES_EN
      else if (edge_q)
        rgb_q <= RGB_GRID;
`endif
      else
        rgb_q <= palette(bus.memval);
    end
  end

  assign bus.vaddr      = vaddr_q;
  assign bus.haddr      = haddr_q;
  assign bus.rgb        = rgb_q;
  assign bus.hsync      = hsync_o;
  assign bus.vsync      = vsync_o;
  assign bus.frame_tick = tick_o;

endmodule

// File: tb/tb_playfield_renderer.sv
// tb/tb_playfield_renderer.sv - self-checking bench for playfield_renderer against a pixel-position model
`timescale 1ns/1ps
module tb_playfield_renderer;

  localparam int OX = 240;
  localparam int OY = 80;
  localparam int CS = 16;
  localparam int BH = 10;
  localparam int BV = 20;
`ifdef GRID_LINES_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        tick;
    logic [4:0]  va;
    logic [4:0]  ha;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mem [0:31][0:31];
  int         total = 0;
  int         bad = 0;
  int         k = 0;
  int         dut_hs_low = 0, exp_hs_low = 0, dut_vs_low = 0, dut_ticks = 0;

  playfield_renderer_if bus ();
  assign bus.memval = mem[bus.vaddr][bus.haddr];

  playfield_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  function automatic logic [11:0] pal(logic [2:0] c);
    logic [11:0] t [8];
    t = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80};
    return t[c];
  endfunction

  function automatic int pos(int h, int v);
    return v * 800 + h;
  endfunction

  // Expected outputs for the pixel at linear position p since reset release (p<0: pipeline still empty).
  function automatic exp_t model(int p);
    exp_t e;
    int   h, v, x, y;
    bit   vis, inf;
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.tick = 1'b0; e.va = 5'd0; e.ha = 5'd0;
    if (p < 0) return e;
    h   = p % 800;
    v   = (p / 800) % 525;
    vis = (h < 640) && (v < 480);
    x   = h - OX;
    y   = v - OY;
    inf = vis && x >= 0 && x < BH * CS && y >= 0 && y < BV * CS;
    e.hs   = !(h >= 656 && h <= 751);
    e.vs   = !(v >= 490 && v <= 491);
    e.tick = (h == 0) && (v == 480);
    if (inf) begin
      e.ha = 5'(x / CS);
      e.va = 5'(y / CS);
    end
    if (!vis)
      e.rgb = 12'h000;
    else if (!inf)
      e.rgb = 12'h333;
    else if (GRID && (x % CS == 0 || y % CS == 0))
      e.rgb = 12'h111;
    else
      e.rgb = pal(mem[y / CS][x / CS]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hsync"}, 12'(bus.hsync), 12'h001);
    chk({tag, "_vsync"}, 12'(bus.vsync), 12'h001);
    chk({tag, "_rgb"}, bus.rgb, 12'h000);
    chk({tag, "_vaddr"}, 12'(bus.vaddr), 12'h000);
    chk({tag, "_haddr"}, 12'(bus.haddr), 12'h000);
    chk({tag, "_tick"}, 12'(bus.frame_tick), 12'h000);
  endtask

  task automatic check_cycle();
    exp_t eo, ea;
    int   po, pa;
    po = k - 2;
    pa = k - 1;
    eo = model(po);
    ea = model(pa);
    chk("rgb", bus.rgb, eo.rgb);
    chk("hsync", 12'(bus.hsync), 12'(eo.hs));
    chk("vsync", 12'(bus.vsync), 12'(eo.vs));
    chk("frame_tick", 12'(bus.frame_tick), 12'(eo.tick));
    chk("vaddr", 12'(bus.vaddr), 12'(ea.va));
    chk("haddr", 12'(bus.haddr), 12'(ea.ha));
    dut_hs_low += (bus.hsync === 1'b0) ? 1 : 0;
    exp_hs_low += eo.hs ? 0 : 1;
    dut_vs_low += (bus.vsync === 1'b0) ? 1 : 0;
    dut_ticks  += (bus.frame_tick === 1'b1) ? 1 : 0;
    if (pa == pos(OX + 53, OY + 37)) begin
      chk("map_haddr", 12'(bus.haddr), 12'd3);
      chk("map_vaddr", 12'(bus.vaddr), 12'd2);
    end
    if (po == pos(OX + 53, OY + 37)) chk("map_rgb", bus.rgb, 12'hFF0);
    if (po == pos(OX - 1, 100))      chk("left_edge_rgb", bus.rgb, 12'h333);
    if (po == pos(OX + 160, 100))    chk("right_edge_rgb", bus.rgb, 12'h333);
    if (pa == pos(OX + 159, 100))    chk("last_col_haddr", 12'(bus.haddr), 12'd9);
    if (pa == pos(300, OY + 319))    chk("last_row_vaddr", 12'(bus.vaddr), 12'd19);
    if (po == pos(700, 100))         chk("blank_rgb", bus.rgb, 12'h000);
    if (po == pos(OX + 16, OY + 5))  chk("grid_pixel_rgb", bus.rgb, GRID ? 12'h111 : 12'h0F0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        mem[r][c] = 3'($urandom_range(0, 7));
    mem[0][0] = 3'd1;
    mem[0][1] = 3'd2;
    mem[2][3] = 3'd4;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_hold");

    reset = 1'b1;
    k = 0;
    run(420000 + 100 * 800 + 300);

    chk("hsync_low_count", 12'(dut_hs_low / 96), 12'(exp_hs_low / 96));
    chk("vsync_low_count", 12'(dut_vs_low), 12'(1600));
    chk("frame_tick_count", 12'(dut_ticks), 12'd1);

    #5;
    reset = 1'b0;
    #1;
    check_reset_values("reset_midline");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_midline_hold");

    reset = 1'b1;
    k = 0;
    run(1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
